// File: rtl/if_id_skid_pipereg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid_pipereg
// Purpose  : IF->ID 2-entry skid pipeline register with flush, opcode
//            pre-decode and a saturating stall counter.
// Revision : 1.0
// ============================================================================
module if_id_skid_pipereg #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_PC_in,
    input  logic [DATA_W-1:0] i_instruction_in,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_PC_out,
    output logic [DATA_W-1:0] o_instruction_out,
    output logic              o_R_type,
    output logic              o_J_type,
    output logic              o_branch,
    output logic              o_mem,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ready;
    logic [DATA_W-1:0]   r_main_pc;
    logic [DATA_W-1:0]   r_main_instr;
    logic [3:0]          r_main_flags;
    logic [DATA_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0]   r_skid_instr;
    logic [3:0]          r_skid_flags;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_accept;
    logic                w_pop;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;
    logic [3:0]          w_in_flags;

    // Flag vector layout: {R, J, branch, mem}
    function automatic logic [3:0] decode_class(input logic [5:0] op);
        logic [3:0] f;
        f    = 4'b0000;
        f[3] = (op == 6'b000000);
        f[2] = (op == 6'b000010) || (op == 6'b000011);
        f[1] = (op == 6'b000100) || (op == 6'b000101);
        f[0] = (op == 6'b100011) || (op == 6'b101011);
        return f;
    endfunction

    assign w_in_flags = decode_class(i_instruction_in[DATA_W-1 -: 6]);
    assign o_valid    = (r_state != ST_EMPTY);
    assign o_ready    = r_ready;
    assign w_accept   = i_valid & r_ready;
    assign w_pop      = o_valid & i_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_state_next = ST_TWO;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state      <= ST_EMPTY;
            r_ready      <= 1'b1;
            r_main_pc    <= '0;
            r_main_instr <= '0;
            r_main_flags <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_flags <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            // Registered so o_ready has no combinational path from i_ready
            r_ready <= (w_state_next != ST_TWO);

            if (o_valid && !i_ready && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (i_flush) begin
                if (FLUSH_ZERO) begin
                    r_main_pc    <= '0;
                    r_main_instr <= '0;
                    r_main_flags <= '0;
                end
            end else if (w_load_main_in) begin
                r_main_pc    <= i_PC_in;
                r_main_instr <= i_instruction_in;
                r_main_flags <= w_in_flags;
            end else if (w_load_main_skid) begin
                r_main_pc    <= r_skid_pc;
                r_main_instr <= r_skid_instr;
                r_main_flags <= r_skid_flags;
            end

            if (w_load_skid) begin
                r_skid_pc    <= i_PC_in;
                r_skid_instr <= i_instruction_in;
                r_skid_flags <= w_in_flags;
            end
        end
    end

    assign o_PC_out          = r_main_pc;
    assign o_instruction_out = r_main_instr;
    assign o_R_type          = r_main_flags[3];
    assign o_J_type          = r_main_flags[2];
    assign o_branch          = r_main_flags[1];
    assign o_mem             = r_main_flags[0];
    assign o_stall_cnt       = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_pipereg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_skid_pipereg
// Purpose  : Directed self-checking bench for if_id_skid_pipereg.
// Revision : 1.0
// ============================================================================
module tb_if_id_skid_pipereg;

    logic        clk = 1'b0;
    logic        rst, valid, flush, ready;
    logic [31:0] pc_in, instr_in;
    wire         o_ready, o_valid, o_r, o_j, o_br, o_mem;
    wire  [31:0] o_pc, o_instr;
    wire  [15:0] o_cnt;

    logic        s_rst, s_valid, s_flush, s_ready;
    logic [31:0] s_pc, s_instr;
    wire         s_o_ready, s_o_valid, s_o_r, s_o_j, s_o_br, s_o_mem;
    wire  [31:0] s_o_pc, s_o_instr;
    wire  [3:0]  s_o_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    if_id_skid_pipereg #(.DATA_W(32), .CNT_W(16), .FLUSH_ZERO(1'b1)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_valid(valid), .o_ready(o_ready),
        .i_PC_in(pc_in), .i_instruction_in(instr_in), .i_flush(flush),
        .o_valid(o_valid), .i_ready(ready), .o_PC_out(o_pc),
        .o_instruction_out(o_instr), .o_R_type(o_r), .o_J_type(o_j),
        .o_branch(o_br), .o_mem(o_mem), .o_stall_cnt(o_cnt)
    );

    if_id_skid_pipereg #(.DATA_W(32), .CNT_W(4), .FLUSH_ZERO(1'b1)) dut_sat (
        .i_sys_clk(clk), .i_sys_rst(s_rst), .i_valid(s_valid), .o_ready(s_o_ready),
        .i_PC_in(s_pc), .i_instruction_in(s_instr), .i_flush(s_flush),
        .o_valid(s_o_valid), .i_ready(s_ready), .o_PC_out(s_o_pc),
        .o_instruction_out(s_o_instr), .o_R_type(s_o_r), .o_J_type(s_o_j),
        .o_branch(s_o_br), .o_mem(s_o_mem), .o_stall_cnt(s_o_cnt)
    );

    // {o_valid, o_ready, R, J, branch, mem}
    wire [5:0] st = {o_valid, o_ready, o_r, o_j, o_br, o_mem};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; valid = 0; flush = 0; ready = 0; pc_in = '0; instr_in = '0;
        s_rst = 1; s_valid = 0; s_flush = 0; s_ready = 0; s_pc = '0; s_instr = '0;
        tick(); tick();
        rst = 0; s_rst = 0;
        tests++;
        if (st !== 6'b010000 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_cnt !== 16'h0) begin
            failed++;
            $display("FAIL reset: st=%b pc=%h instr=%h cnt=%0d, want st=010000 pc=0 instr=0 cnt=0",
                     st, o_pc, o_instr, o_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3]    = '{32'h0, 32'h4, 32'h8};
        logic [31:0] ins [3]    = '{32'h012A4020, 32'h08000010, 32'h8D090004};
        logic [5:0]  exp_st [3] = '{6'b111000, 6'b110100, 6'b110001};
        ready = 1; valid = 1;
        for (int k = 0; k < 3; k++) begin
            pc_in = pcs[k]; instr_in = ins[k];
            tick();
            tests++;
            if (st !== exp_st[k] || o_pc !== pcs[k] || o_instr !== ins[k]) begin
                failed++;
                $display("FAIL stream[%0d]: st=%b pc=%h instr=%h, want st=%b pc=%h instr=%h",
                         k, st, o_pc, o_instr, exp_st[k], pcs[k], ins[k]);
            end
        end
        tests++;
        if (o_cnt !== 16'd0) begin
            failed++;
            $display("FAIL stream_cnt: cnt=%0d, want 0", o_cnt);
        end
    endtask

    task automatic test_backpressure();
        valid = 1; ready = 1; pc_in = 32'h10; instr_in = 32'hAD090000;
        tick();
        ready = 0; pc_in = 32'h14; instr_in = 32'hAD090004;
        tick();
        tests++;
        if (o_ready !== 1'b0 || o_pc !== 32'h10 || o_valid !== 1'b1) begin
            failed++;
            $display("FAIL bp_skid: o_ready=%b pc=%h valid=%b, want 0 00000010 1", o_ready, o_pc, o_valid);
        end
        pc_in = 32'h18; instr_in = 32'hAD090008;
        tick(); tick();
        tests++;
        if (o_cnt !== 16'd3 || o_pc !== 32'h10 || o_instr !== 32'hAD090000 || o_ready !== 1'b0) begin
            failed++;
            $display("FAIL bp_hold: cnt=%0d pc=%h instr=%h rdy=%b, want 3 00000010 ad090000 0",
                     o_cnt, o_pc, o_instr, o_ready);
        end
        ready = 1;
        tick();
        tests++;
        if (o_pc !== 32'h14 || o_instr !== 32'hAD090004 || o_ready !== 1'b1 || o_valid !== 1'b1) begin
            failed++;
            $display("FAIL bp_drain1: pc=%h instr=%h rdy=%b valid=%b, want 00000014 ad090004 1 1",
                     o_pc, o_instr, o_ready, o_valid);
        end
        tick();
        tests++;
        if (o_pc !== 32'h18 || o_valid !== 1'b1 || o_cnt !== 16'd3) begin
            failed++;
            $display("FAIL bp_drain2: pc=%h valid=%b cnt=%0d, want 00000018 1 3", o_pc, o_valid, o_cnt);
        end
        valid = 0;
        tick();
        tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failed++;
            $display("FAIL bp_empty: valid=%b rdy=%b, want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_flush();
        valid = 1; ready = 0; pc_in = 32'h30; instr_in = 32'h012A4020;
        tick();
        pc_in = 32'h34; instr_in = 32'h08000010;
        tick();
        tests++;
        if (o_ready !== 1'b0 || o_cnt !== 16'd4) begin
            failed++;
            $display("FAIL flush_setup: rdy=%b cnt=%0d, want 0 4", o_ready, o_cnt);
        end
        flush = 1; pc_in = 32'h20; instr_in = 32'h8D090004;
        tick();
        flush = 0; valid = 0;
        tests++;
        if (st !== 6'b010000 || o_instr !== 32'h0 || o_pc !== 32'h0 || o_cnt !== 16'd5) begin
            failed++;
            $display("FAIL flush: st=%b pc=%h instr=%h cnt=%0d, want 010000 0 0 5",
                     st, o_pc, o_instr, o_cnt);
        end
        tick();
        tests++;
        if (o_valid !== 1'b0 || o_pc === 32'h20) begin
            failed++;
            $display("FAIL flush_discard: valid=%b pc=%h, want valid 0 and pc not 00000020", o_valid, o_pc);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [2] = '{32'h11090003, 32'h15090003};
        valid = 1; ready = 1;
        for (int k = 0; k < 2; k++) begin
            pc_in = 32'h40 + 32'(4 * k); instr_in = ins[k];
            tick();
            tests++;
            if (st !== 6'b110010 || o_instr !== ins[k]) begin
                failed++;
                $display("FAIL branch[%0d]: st=%b instr=%h, want 110010 %h", k, st, o_instr, ins[k]);
            end
        end
        valid = 0;
        tick();
    endtask

    task automatic test_saturation();
        s_valid = 1; s_ready = 0; s_pc = 32'h100; s_instr = 32'h012A4020;
        tick();
        s_valid = 0;
        for (int k = 0; k < 10; k++) tick();
        tests++;
        if (s_o_cnt !== 4'd10) begin
            failed++;
            $display("FAIL sat_mid: cnt=%0d, want 10", s_o_cnt);
        end
        for (int k = 0; k < 10; k++) tick();
        tests++;
        if (s_o_cnt !== 4'd15) begin
            failed++;
            $display("FAIL sat_20: cnt=%0d, want 15", s_o_cnt);
        end
        for (int k = 0; k < 5; k++) tick();
        tests++;
        if (s_o_cnt !== 4'd15 || s_o_valid !== 1'b1 || s_o_pc !== 32'h100) begin
            failed++;
            $display("FAIL sat_hold: cnt=%0d valid=%b pc=%h, want 15 1 00000100", s_o_cnt, s_o_valid, s_o_pc);
        end
    endtask

    task automatic test_reset_mid();
        valid = 1; ready = 0; pc_in = 32'h50; instr_in = 32'h08000010;
        tick();
        pc_in = 32'h54; instr_in = 32'h8D090004;
        tick();
        tests++;
        if (o_ready !== 1'b0 || o_pc !== 32'h50) begin
            failed++;
            $display("FAIL rstmid_setup: rdy=%b pc=%h, want 0 00000050", o_ready, o_pc);
        end
        rst = 1; flush = 1; pc_in = 32'h58;
        tick();
        rst = 0; flush = 0; valid = 0;
        tests++;
        if (st !== 6'b010000 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_cnt !== 16'd0) begin
            failed++;
            $display("FAIL rstmid: st=%b pc=%h instr=%h cnt=%0d, want 010000 0 0 0",
                     st, o_pc, o_instr, o_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_branch();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
